// File: rtl/ramp_pkg.sv
// Shared definitions for the ramp sequencer.
//  - Default widths for the period, prescale and ramp-count buses.
//  - State encoding of the sequencer FSM.
package ramp_pkg;

    localparam int CNT_W = 32;
    localparam int PRE_W = 16;
    localparam int NUM_W = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        WAIT_EXT = 3'd2,
        RUN      = 3'd3,
        DONE     = 3'd4
    } ramp_state_t;

endpackage

// File: rtl/ramp_prescaler.sv
// Trig prescaler: tick is high whenever the internal count is zero, and the
// count advances on en, wrapping to zero after it has reached div. A tick
// therefore occurs once every div+1 enabled clocks, starting immediately
// after a clear.
// Ports:
//  clk    in  system clock
//  reset  in  synchronous active-low reset
//  clr    in  synchronous clear of the count (wins over en)
//  en     in  advance the count
//  div    in  PRE_W terminal value of the count
//  tick   out count==0
module ramp_prescaler #(
    parameter int PRE_W = ramp_pkg::PRE_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [PRE_W-1:0] div,
    output logic             tick
);

    logic [PRE_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= (cnt_reg == div) ? '0 : cnt_reg + PRE_W'(1);
        end
    end

    assign tick = (cnt_reg == '0);

endmodule

// File: rtl/ramp_seq_ctrl.sv
// Ramp sequencer: latches a run configuration, clears the external ramp
// counter, paces it with a prescaled trig and counts its wraps (rising edges
// of ramp_rst). A run ends after cfg_nramps wraps, or on stop when
// cfg_nramps is 0 (continuous).
// Ports:
//  clk, reset          clock, synchronous active-low reset
//  start, stop         1-cycle run request / abort request
//  ext_trig_en         wait for an ext_trig rising edge before running
//  ext_trig            external sync (clk domain)
//  cfg_period          ramp terminal count, latched on accepted start
//  cfg_prescale        trig once every cfg_prescale+1 clocks
//  cfg_nramps          ramps per run, 0 = continuous
//  ramp_rst            wrap indication from the ramp counter
//  ramp_trig           trig/enable to the ramp counter
//  ramp_ref_cnt        latched period to the ramp counter
//  ramp_clr            clear for the ramp counter (ARM and DONE)
//  busy                run in progress (ARM, WAIT_EXT, RUN)
//  done                1-cycle pulse at run end
//  cfg_err             1-cycle pulse after a start rejected for period 0
//  ramp_count          ramps completed in the current/last run
module ramp_seq_ctrl #(
    parameter int CNT_W = ramp_pkg::CNT_W,
    parameter int PRE_W = ramp_pkg::PRE_W,
    parameter int NUM_W = ramp_pkg::NUM_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             ext_trig_en,
    input  logic             ext_trig,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [PRE_W-1:0] cfg_prescale,
    input  logic [NUM_W-1:0] cfg_nramps,
    input  logic             ramp_rst,
    output logic             ramp_trig,
    output logic [CNT_W-1:0] ramp_ref_cnt,
    output logic             ramp_clr,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [NUM_W-1:0] ramp_count
);

    import ramp_pkg::*;

    ramp_state_t      state_reg, state_next;
    logic [CNT_W-1:0] period_reg;
    logic [PRE_W-1:0] prescale_reg;
    logic [NUM_W-1:0] nramps_reg;
    logic [NUM_W-1:0] count_reg;
    logic [NUM_W-1:0] count_plus;
    logic             rst_prev_reg;
    logic             ext_prev_reg;
    logic             cfg_err_reg;

    logic rst_edge, ext_edge;
    logic start_ok, start_bad;
    logic count_inc, count_hit;
    logic pre_clr, pre_en, pre_tick;

    assign rst_edge   = ramp_rst & ~rst_prev_reg;
    assign ext_edge   = ext_trig & ~ext_prev_reg;
    assign start_ok   = (state_reg == IDLE) && start && (cfg_period != '0);
    assign start_bad  = (state_reg == IDLE) && start && (cfg_period == '0);
    assign count_plus = count_reg + NUM_W'(1);
    assign count_inc  = (state_reg == RUN) && rst_edge;
    // Compare against the incremented value so the run ends on the wrap
    // that completes the last ramp, not one wrap later.
    assign count_hit  = count_inc && (nramps_reg != '0) && (count_plus == nramps_reg);

    // Prescaler is held at zero through ARM and WAIT_EXT so the very first
    // RUN cycle produces a trig.
    assign pre_clr = (state_reg == ARM);
    assign pre_en  = (state_reg == RUN);

    ramp_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (pre_clr),
        .en    (pre_en),
        .div   (prescale_reg),
        .tick  (pre_tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            period_reg   <= '0;
            prescale_reg <= '0;
            nramps_reg   <= '0;
            count_reg    <= '0;
            rst_prev_reg <= 1'b0;
            ext_prev_reg <= 1'b0;
            cfg_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rst_prev_reg <= ramp_rst;
            ext_prev_reg <= ext_trig;
            cfg_err_reg  <= start_bad;
            if (start_ok) begin
                period_reg   <= cfg_period;
                prescale_reg <= cfg_prescale;
                nramps_reg   <= cfg_nramps;
                count_reg    <= '0;
            end else if (count_inc) begin
                count_reg <= count_plus;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        ramp_trig  = 1'b0;
        ramp_clr   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_ok) state_next = ARM;
            end
            ARM: begin
                busy     = 1'b1;
                ramp_clr = 1'b1;
                if (stop)             state_next = DONE;
                else if (ext_trig_en) state_next = WAIT_EXT;
                else                  state_next = RUN;
            end
            WAIT_EXT: begin
                busy = 1'b1;
                if (stop)          state_next = DONE;
                else if (ext_edge) state_next = RUN;
            end
            RUN: begin
                busy      = 1'b1;
                ramp_trig = pre_tick;
                // The count still advances on a coincident wrap; stop only
                // decides the exit.
                if (stop || count_hit) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                ramp_clr   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign ramp_ref_cnt = period_reg;
    assign cfg_err      = cfg_err_reg;
    assign ramp_count   = count_reg;

endmodule

// File: tb/tb_ramp_seq_ctrl.sv
`timescale 1ns/1ps
module tb_ramp_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        ext_trig_en = 1'b0;
    logic        ext_trig = 1'b0;
    logic [31:0] cfg_period = '0;
    logic [15:0] cfg_prescale = '0;
    logic [15:0] cfg_nramps = '0;
    logic        ramp_rst;
    logic        ramp_trig;
    logic [31:0] ramp_ref_cnt;
    logic        ramp_clr;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic [15:0] ramp_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ramp_seq_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .ext_trig_en  (ext_trig_en),
        .ext_trig     (ext_trig),
        .cfg_period   (cfg_period),
        .cfg_prescale (cfg_prescale),
        .cfg_nramps   (cfg_nramps),
        .ramp_rst     (ramp_rst),
        .ramp_trig    (ramp_trig),
        .ramp_ref_cnt (ramp_ref_cnt),
        .ramp_clr     (ramp_clr),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err),
        .ramp_count   (ramp_count)
    );

    // Ramp counter the sequencer drives: counts on trig, wraps after
    // reaching Ref_CNT, RstOut while at the terminal count; ramp_clr is
    // ORed into its reset.
    logic [31:0] rc_cnt;
    always @(posedge clk) begin
        if (!reset || ramp_clr)
            rc_cnt <= '0;
        else if (ramp_trig)
            rc_cnt <= (rc_cnt == ramp_ref_cnt) ? 32'd0 : rc_cnt + 32'd1;
    end
    assign ramp_rst = (rc_cnt == ramp_ref_cnt);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: phase of the run, cycles spent running (trig is
    // every (prescale+1)-th running cycle), latched config and wrap count.
    typedef enum {P_IDLE, P_ARM, P_WAIT, P_RUN, P_DONE} phase_t;
    phase_t      m_ph = P_IDLE;
    int          m_run_cyc = 0;
    logic [31:0] m_period = '0;
    int          m_pre = 0;
    logic [15:0] m_n = '0;
    logic [15:0] m_cnt = '0;
    bit          m_err = 0;
    bit          m_prev_rst = 0;
    bit          m_prev_ext = 0;
    bit          m_valid = 0;

    always @(posedge clk) begin
        bit redge, eedge;
        if (!reset) begin
            m_ph <= P_IDLE; m_run_cyc <= 0; m_period <= '0; m_pre <= 0;
            m_n <= '0; m_cnt <= '0; m_err <= 0; m_prev_rst <= 0; m_prev_ext <= 0;
            m_valid <= 1;
        end else begin
            redge = (ramp_rst === 1'b1) && !m_prev_rst;
            eedge = ext_trig && !m_prev_ext;
            m_prev_rst <= (ramp_rst === 1'b1);
            m_prev_ext <= ext_trig;
            m_err <= (m_ph == P_IDLE) && start && (cfg_period == 0);
            case (m_ph)
                P_IDLE: if (start && cfg_period != 0) begin
                    m_period <= cfg_period; m_pre <= int'(cfg_prescale);
                    m_n <= cfg_nramps; m_cnt <= '0; m_ph <= P_ARM;
                end
                P_ARM: begin
                    m_run_cyc <= 0;
                    m_ph <= stop ? P_DONE : (ext_trig_en ? P_WAIT : P_RUN);
                end
                P_WAIT: begin
                    if (stop) m_ph <= P_DONE;
                    else if (eedge) m_ph <= P_RUN;
                end
                P_RUN: begin
                    m_run_cyc <= m_run_cyc + 1;
                    if (redge) m_cnt <= m_cnt + 16'd1;
                    if (stop || (redge && m_n != 0 && m_cnt + 16'd1 == m_n)) m_ph <= P_DONE;
                end
                P_DONE: m_ph <= P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("trig", ramp_trig, (m_ph == P_RUN) && (m_run_cyc % (m_pre + 1) == 0));
            check("ref_cnt", ramp_ref_cnt, m_period);
            check("clr", ramp_clr, (m_ph == P_ARM) || (m_ph == P_DONE));
            check("busy", busy, (m_ph == P_ARM) || (m_ph == P_WAIT) || (m_ph == P_RUN));
            check("done", done, m_ph == P_DONE);
            check("cfg_err", cfg_err, m_err);
            check("ramp_count", ramp_count, m_cnt);
        end
    end

    // Advance to just after the next rising edge; start/stop are pulses.
    task automatic cyc();
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic launch(input logic [31:0] per, input logic [15:0] pre,
                          input logic [15:0] n, input logic ext_en);
        cyc();
        cfg_period = per; cfg_prescale = pre; cfg_nramps = n; ext_trig_en = ext_en;
        start = 1'b1;
    endtask

    task automatic wait_done(input string nm, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            cyc();
            @(negedge clk);
            if (done) seen = 1;
        end
        check(nm, seen, 1);
    endtask

    // Count ramp_rst rising edges; stop either in the edge cycle of the
    // target edge or one cycle later. Returns positioned in the DONE cycle.
    task automatic edges_then_stop(input string nm, input int target, input bit on_edge, input int budget);
        int n = 0;
        bit p;
        p = ramp_rst;
        for (int i = 0; i < budget && n < target; i++) begin
            cyc();
            if (ramp_rst && !p) begin
                n++;
                if (on_edge && n == target) stop = 1'b1;
            end
            p = ramp_rst;
        end
        check(nm, n, target);
        if (!on_edge) begin
            cyc();
            stop = 1'b1;
        end
        cyc();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        logic [31:0] per;
        logic [15:0] pre, n;
        logic        ee;

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_trig", ramp_trig, 0);
        check("rst_ref", ramp_ref_cnt, 0);
        check("rst_count", ramp_count, 0);
        check("rst_done", done, 0);
        check("rst_clr", ramp_clr, 0);

        // 1: exact timeline
        launch(32'd3, 16'd0, 16'd2, 1'b0);
        for (int c = 1; c <= 11; c++) begin
            cyc();
            @(negedge clk);
            case (c)
                1: begin check("t1_arm_clr", ramp_clr, 1); check("t1_arm_trig", ramp_trig, 0); check("t1_arm_busy", busy, 1); end
                2: check("t1_first_trig", ramp_trig, 1);
                5: check("t1_rst_c5", ramp_rst, 1);
                6: check("t1_count_c6", ramp_count, 1);
                9: check("t1_rst_c9", ramp_rst, 1);
                10: begin check("t1_done_c10", done, 1); check("t1_count", ramp_count, 2); end
                11: begin check("t1_busy_c11", busy, 0); check("t1_done_c11", done, 0); end
                default: ;
            endcase
        end
        $display("TXN directed1 period=3 pre=0 n=2 ramp_count=%0d", ramp_count);

        // 2: prescaled trig
        launch(32'd3, 16'd1, 16'd1, 1'b0);
        cyc();
        for (int c = 2; c <= 5; c++) begin
            cyc();
            @(negedge clk);
            check("t2_trig_pattern", ramp_trig, (c % 2 == 0) ? 1 : 0);
        end
        wait_done("t2_done_seen", 40);
        check("t2_count", ramp_count, 1);
        $display("TXN directed2 period=3 pre=1 n=1 ramp_count=%0d", ramp_count);

        // 3: zero period rejected
        launch(32'd0, 16'd0, 16'd1, 1'b0);
        cyc();
        @(negedge clk);
        check("t3_err_pulse", cfg_err, 1);
        check("t3_busy", busy, 0);
        check("t3_trig", ramp_trig, 0);
        cyc();
        @(negedge clk);
        check("t3_err_clear", cfg_err, 0);
        check("t3_busy2", busy, 0);
        $display("TXN directed3 period=0 cfg_err_pulse");

        // 4: external trigger wait with ext_trig already high
        ext_trig = 1'b1;
        launch(32'd2, 16'd0, 16'd0, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            cyc();
            @(negedge clk);
            if (c >= 2) begin check("t4_wait_trig", ramp_trig, 0); check("t4_wait_busy", busy, 1); end
        end
        cyc(); ext_trig = 1'b0;
        @(negedge clk);
        check("t4_low_trig", ramp_trig, 0);
        cyc(); ext_trig = 1'b1;
        @(negedge clk);
        check("t4_edge_trig", ramp_trig, 0);
        cyc();
        @(negedge clk);
        check("t4_run_trig", ramp_trig, 1);
        cyc(); stop = 1'b1;
        wait_done("t4_done_seen", 5);
        $display("TXN directed4 ext wait period=2 ramp_count=%0d", ramp_count);
        ext_trig = 1'b0;

        // 5: continuous, stop after 5 edges, then stop on the 6th edge
        launch(32'd2, 16'd0, 16'd0, 1'b0);
        edges_then_stop("t5a_edges", 5, 1'b0, 100);
        @(negedge clk);
        check("t5a_done", done, 1);
        check("t5a_count", ramp_count, 5);
        $display("TXN directed5a continuous stop ramp_count=%0d", ramp_count);
        launch(32'd2, 16'd0, 16'd0, 1'b0);
        edges_then_stop("t5b_edges", 6, 1'b1, 100);
        @(negedge clk);
        check("t5b_done", done, 1);
        check("t5b_count", ramp_count, 6);
        $display("TXN directed5b stop on edge ramp_count=%0d", ramp_count);

        // 6: start during RUN ignored, then reset mid-run
        launch(32'd5, 16'd2, 16'd0, 1'b0);
        repeat (6) cyc();
        cfg_period = 32'd7; cfg_prescale = 16'd0; cfg_nramps = 16'd3; start = 1'b1;
        cyc();
        @(negedge clk);
        check("t6_ref_kept", ramp_ref_cnt, 5);
        check("t6_busy_kept", busy, 1);
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_ref", ramp_ref_cnt, 0);
        check("t6_rst_count", ramp_count, 0);
        check("t6_rst_trig", ramp_trig, 0);
        cyc();
        @(negedge clk);
        check("t6_no_done", done, 0);
        $display("TXN directed6 reset mid-run");

        // Randomized runs
        for (int t = 0; t < 30; t++) begin
            per = 32'($urandom_range(0, 5));
            pre = 16'($urandom_range(0, 3));
            n   = 16'($urandom_range(0, 4));
            ee  = 1'($urandom_range(0, 1));
            launch(per, pre, n, ee);
            cyc();
            cycles = 0;
            while ((busy || done) && cycles < 400) begin
                if ($urandom_range(0, 3) == 0) ext_trig = ~ext_trig;
                stop  = ($urandom_range(0, 59) == 0) || (cycles == 300);
                start = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 7) == 0) begin
                    cfg_period   = $urandom_range(0, 9);
                    cfg_prescale = 16'($urandom_range(0, 5));
                    cfg_nramps   = 16'($urandom_range(0, 5));
                end
                cyc();
                cycles++;
            end
            check("rand_run_ends", (cycles < 400) ? 1 : 0, 1);
            $display("TXN rand%0d period=%0d pre=%0d n=%0d ext=%0d ramp_count=%0d cycles=%0d",
                     t, per, pre, n, ee, ramp_count, cycles);
        end

        repeat (2) cyc();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
